// File: rtl/bfly_r2_stage_if.sv
// Vector stream bundle for the radix-2 butterfly stage.
// master: drives in_*, din_*, out_ready, ovf_clr; slave: the stage.
interface bfly_r2_stage_if #(
  parameter int WIDTH     = 13,
  parameter int LANES     = 16,
  parameter int OUT_WIDTH = 14
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic                       scale_en;
  logic [LANES*WIDTH-1:0]     din_re;
  logic [LANES*WIDTH-1:0]     din_im;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic [LANES*OUT_WIDTH-1:0] dout_re;
  logic [LANES*OUT_WIDTH-1:0] dout_im;
  logic                       ovf_clr;
  logic                       ovf_sticky;

  modport master (
    output in_valid, in_last, scale_en,
    output din_re, din_im,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_last,
    input  dout_re, dout_im, ovf_sticky
  );

  modport slave (
    input  in_valid, in_last, scale_en,
    input  din_re, din_im,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_last,
    output dout_re, dout_im, ovf_sticky
  );
endinterface

// File: rtl/bfly_r2_stage.sv
// Radix-2 butterfly stage: stride pairing, optional /2, saturation.
// Ports: clk, rst (sync, high), bus (stream in/out, ovf flag).
module bfly_r2_stage #(
  parameter int WIDTH     = 13,
  parameter int LANES     = 16,
  parameter int STRIDE    = 8,
  parameter int OUT_WIDTH = 14
) (
  input  logic           clk,
  input  logic           rst,
  bfly_r2_stage_if.slave bus
);
  localparam int SW = WIDTH + 1;
  localparam int RW = WIDTH + 2;
  localparam logic signed [RW-1:0] OMAX =
    RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN =
    RW'(-(1 << (OUT_WIDTH - 1)));

  logic v1, v2;
  logic s1_ld, s2_ld, acc;
  logic sc1, last1, last2, ovf;
  logic any_clip;

  logic signed [SW-1:0] sum_re [LANES];
  logic signed [SW-1:0] sum_im [LANES];
  logic signed [SW-1:0] s1_re  [LANES];
  logic signed [SW-1:0] s1_im  [LANES];
  logic signed [OUT_WIDTH-1:0] sat_re [LANES];
  logic signed [OUT_WIDTH-1:0] sat_im [LANES];
  logic clip_re [LANES];
  logic clip_im [LANES];

  logic [LANES*OUT_WIDTH-1:0] o_re, o_im;

  // No skid buffer: ready ripples back combinationally.
  assign s2_ld = !v2 || bus.out_ready;
  assign s1_ld = !v1 || s2_ld;
  assign bus.in_ready = !rst && s1_ld;
  assign acc = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam bit LO = (i % (2 * STRIDE)) < STRIDE;
    localparam int J  = LO ? i + STRIDE : i - STRIDE;

    logic signed [WIDTH-1:0] xi_re, xi_im;
    logic signed [WIDTH-1:0] xj_re, xj_im;
    logic signed [RW-1:0]    r_re, r_im;

    assign xi_re = bus.din_re[i*WIDTH +: WIDTH];
    assign xi_im = bus.din_im[i*WIDTH +: WIDTH];
    assign xj_re = bus.din_re[J*WIDTH +: WIDTH];
    assign xj_im = bus.din_im[J*WIDTH +: WIDTH];

    if (LO) begin : g_add
      assign sum_re[i] = SW'(xi_re) + SW'(xj_re);
      assign sum_im[i] = SW'(xi_im) + SW'(xj_im);
    end else begin : g_sub
      assign sum_re[i] = SW'(xj_re) - SW'(xi_re);
      assign sum_im[i] = SW'(xj_im) - SW'(xi_im);
    end

    // Round half up: add one before the arithmetic shift.
    assign r_re = sc1 ? (RW'(s1_re[i]) + RW'(1)) >>> 1
                      : RW'(s1_re[i]);
    assign r_im = sc1 ? (RW'(s1_im[i]) + RW'(1)) >>> 1
                      : RW'(s1_im[i]);

    assign clip_re[i] = (r_re > OMAX) || (r_re < OMIN);
    assign clip_im[i] = (r_im > OMAX) || (r_im < OMIN);

    assign sat_re[i] =
      (r_re > OMAX) ? OMAX[OUT_WIDTH-1:0] :
      (r_re < OMIN) ? OMIN[OUT_WIDTH-1:0] :
                      r_re[OUT_WIDTH-1:0];
    assign sat_im[i] =
      (r_im > OMAX) ? OMAX[OUT_WIDTH-1:0] :
      (r_im < OMIN) ? OMIN[OUT_WIDTH-1:0] :
                      r_im[OUT_WIDTH-1:0];
  end

  always_comb begin
    any_clip = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      any_clip = any_clip | clip_re[i] | clip_im[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sc1   <= 1'b0;
      last1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
      end
    end else if (s1_ld) begin
      v1 <= acc;
      if (acc) begin
        sc1   <= bus.scale_en;
        last1 <= bus.in_last;
        for (int i = 0; i < LANES; i++) begin
          s1_re[i] <= sum_re[i];
          s1_im[i] <= sum_im[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      o_re  <= '0;
      o_im  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (s2_ld) begin
        v2    <= v1;
        last2 <= v1 && last1;
        if (v1) begin
          for (int i = 0; i < LANES; i++) begin
            o_re[i*OUT_WIDTH +: OUT_WIDTH] <= sat_re[i];
            o_im[i*OUT_WIDTH +: OUT_WIDTH] <= sat_im[i];
          end
        end
      end
      // A new clip wins over a simultaneous clear.
      ovf <= (s2_ld && v1 && any_clip) ||
             (ovf && !bus.ovf_clr);
    end
  end

  assign bus.out_valid  = v2;
  assign bus.out_last   = last2;
  assign bus.dout_re    = o_re;
  assign bus.dout_im    = o_im;
  assign bus.ovf_sticky = ovf;
endmodule

// File: tb/tb_bfly_r2_stage.sv
// Bench for bfly_r2_stage: three parameter sets, random streams,
// arithmetic reference model, flow-control and reset scenarios.
module tb_bfly_r2_stage;
  typedef int vec_t [16];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bfly_r2_stage_if #(.WIDTH(13), .LANES(16), .OUT_WIDTH(14)) ia ();
  bfly_r2_stage_if #(.WIDTH(13), .LANES(4),  .OUT_WIDTH(14)) ib ();
  bfly_r2_stage_if #(.WIDTH(13), .LANES(16), .OUT_WIDTH(13)) ic ();

  bfly_r2_stage #(
    .WIDTH(13), .LANES(16), .STRIDE(8), .OUT_WIDTH(14)
  ) ua (.clk(clk), .rst(rst), .bus(ia));

  bfly_r2_stage #(
    .WIDTH(13), .LANES(4), .STRIDE(1), .OUT_WIDTH(14)
  ) ub (.clk(clk), .rst(rst), .bus(ib));

  bfly_r2_stage #(
    .WIDTH(13), .LANES(16), .STRIDE(8), .OUT_WIDTH(13)
  ) uc (.clk(clk), .rst(rst), .bus(ic));

  function automatic logic [16*13-1:0] pack13(vec_t x);
    logic [16*13-1:0] p;
    logic [31:0] t;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      t = x[i];
      p[i*13 +: 13] = t[12:0];
    end
    return p;
  endfunction

  function automatic int get_lane(logic [223:0] b, int i, int ow);
    logic [223:0] sh;
    int v;
    sh = b >> (i * ow);
    v = int'(sh[31:0]) & ((1 << ow) - 1);
    if (v >= (1 << (ow - 1))) v -= (1 << ow);
    return v;
  endfunction

  function automatic int ref_raw(vec_t x, int stride, bit sc, int i);
    int s;
    if ((i % (2 * stride)) < stride) s = x[i] + x[i + stride];
    else s = x[i - stride] - x[i];
    if (sc) return $rtoi($floor(real'(s + 1) / 2.0));
    return s;
  endfunction

  function automatic int sat(int r, int ow);
    int hi, lo;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  function automatic int vec_errs(logic [223:0] dre, logic [223:0] dim,
                                 vec_t xr, vec_t xi, int lanes,
                                 int stride, int ow, bit sc);
    int e = 0;
    for (int i = 0; i < lanes; i++) begin
      if (get_lane(dre, i, ow) != sat(ref_raw(xr, stride, sc, i), ow))
        e++;
      if (get_lane(dim, i, ow) != sat(ref_raw(xi, stride, sc, i), ow))
        e++;
    end
    return e;
  endfunction

  function automatic int rnd13();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic send_a(vec_t xr, vec_t xi, bit sc, bit last);
    @(negedge clk);
    ia.din_re   = pack13(xr);
    ia.din_im   = pack13(xi);
    ia.scale_en = sc;
    ia.in_last  = last;
    ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
  endtask

  task automatic send_c(vec_t xr, vec_t xi, bit sc);
    @(negedge clk);
    ic.din_re   = pack13(xr);
    ic.din_im   = pack13(xi);
    ic.scale_en = sc;
    ic.in_valid = 1'b1;
    @(negedge clk);
    ic.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (ia.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_ready: got %b want 0", ia.in_ready);
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_last, ia.ovf_sticky} !== 3'b000 ||
        ia.dout_re !== '0 || ia.dout_im !== '0) begin
      n_bad++;
      $display("FAIL rst_a: v=%b l=%b o=%b re=%h want all 0",
               ia.out_valid, ia.out_last, ia.ovf_sticky, ia.dout_re);
    end
    n_cmp++;
    if ({ib.out_valid, ib.out_last, ib.ovf_sticky} !== 3'b000 ||
        ib.dout_re !== '0 || ib.dout_im !== '0) begin
      n_bad++;
      $display("FAIL rst_b: v=%b l=%b o=%b want all 0",
               ib.out_valid, ib.out_last, ib.ovf_sticky);
    end
    n_cmp++;
    if ({ic.out_valid, ic.out_last, ic.ovf_sticky} !== 3'b000 ||
        ic.dout_re !== '0 || ic.dout_im !== '0) begin
      n_bad++;
      $display("FAIL rst_c: v=%b l=%b o=%b want all 0",
               ic.out_valid, ic.out_last, ic.ovf_sticky);
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec_t xr, xi;
    int e;
    for (int i = 0; i < 8; i++) begin
      xr[i] = i;
      xr[i + 8] = 100;
    end
    for (int i = 0; i < 16; i++) xi[i] = -xr[i];
    send_a(xr, xi, 1'b0, 1'b0);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: out_valid %b want 0", ia.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: out_valid %b want 1", ia.out_valid);
    end
    e = vec_errs(ia.dout_re, ia.dout_im, xr, xi, 16, 8, 14, 1'b0);
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL basic_data: %0d lane errors want 0", e);
    end
    n_cmp++;
    if (get_lane(ia.dout_re, 0, 14) !== 100 ||
        get_lane(ia.dout_re, 15, 14) !== -93 ||
        get_lane(ia.dout_im, 8, 14) !== 100) begin
      n_bad++;
      $display("FAIL basic_const: re0=%0d re15=%0d im8=%0d want 100 -93 100",
               get_lane(ia.dout_re, 0, 14), get_lane(ia.dout_re, 15, 14),
               get_lane(ia.dout_im, 8, 14));
    end
    n_cmp++;
    if (ia.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ovf: got %b want 0", ia.ovf_sticky);
    end
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_dup: out_valid %b want 0", ia.out_valid);
    end
  endtask

  task automatic test_stride1();
    vec_t xr, xi;
    logic [16*13-1:0] pr, pi;
    int e;
    int ex [4];
    ex = '{8, 2, -5, -9};
    for (int i = 0; i < 16; i++) begin
      xr[i] = 0;
      xi[i] = (i < 4) ? rnd13() : 0;
    end
    xr[0] = 5; xr[1] = 3; xr[2] = -7; xr[3] = 2;
    pr = pack13(xr);
    pi = pack13(xi);
    @(negedge clk);
    ib.din_re   = pr[51:0];
    ib.din_im   = pi[51:0];
    ib.scale_en = 1'b0;
    ib.in_valid = 1'b1;
    @(negedge clk);
    ib.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ib.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL s1_valid: out_valid %b want 1", ib.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (get_lane({168'b0, ib.dout_re}, i, 14) !== ex[i]) begin
        n_bad++;
        $display("FAIL s1_lane%0d: got %0d want %0d", i,
                 get_lane({168'b0, ib.dout_re}, i, 14), ex[i]);
      end
    end
    e = vec_errs({168'b0, ib.dout_re}, {168'b0, ib.dout_im},
                 xr, xi, 4, 1, 14, 1'b0);
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL s1_model: %0d lane errors want 0", e);
    end
  endtask

  task automatic test_scale();
    vec_t ar, ai, br, bi;
    int ex [4];
    int e;
    ex = '{2, -1, 0, 1};
    for (int i = 0; i < 16; i++) begin
      ar[i] = rnd13(); ai[i] = rnd13();
      br[i] = rnd13(); bi[i] = rnd13();
    end
    ar[0] = 1;  ar[8]  = 2;
    ar[1] = -1; ar[9]  = -2;
    ar[2] = 0;  ar[10] = -1;
    ar[3] = 0;  ar[11] = 1;
    @(negedge clk);
    ia.din_re = pack13(ar); ia.din_im = pack13(ai);
    ia.scale_en = 1'b1; ia.in_last = 1'b0; ia.in_valid = 1'b1;
    @(negedge clk);
    ia.din_re = pack13(br); ia.din_im = pack13(bi);
    ia.scale_en = 1'b0;
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sc_early: out_valid %b want 0", ia.out_valid);
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    n_cmp++;
    if (ia.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sc_valid1: out_valid %b want 1", ia.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (get_lane(ia.dout_re, i, 14) !== ex[i]) begin
        n_bad++;
        $display("FAIL sc_round%0d: got %0d want %0d", i,
                 get_lane(ia.dout_re, i, 14), ex[i]);
      end
    end
    e = vec_errs(ia.dout_re, ia.dout_im, ar, ai, 16, 8, 14, 1'b1);
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL sc_model1: %0d lane errors want 0", e);
    end
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sc_valid2: out_valid %b want 1", ia.out_valid);
    end
    e = vec_errs(ia.dout_re, ia.dout_im, br, bi, 16, 8, 14, 1'b0);
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL sc_model2: %0d lane errors want 0", e);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    vec_t xr, xi;
    int e;
    for (int i = 0; i < 16; i++) begin
      xr[i] = 0; xi[i] = 0;
    end
    xr[0] = 4095;  xr[8] = 4095;
    xi[0] = -4096; xi[8] = -4096;
    send_c(xr, xi, 1'b0);
    n_cmp++;
    if (ic.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_early: ovf %b want 0", ic.ovf_sticky);
    end
    @(negedge clk);
    n_cmp++;
    if (get_lane({16'b0, ic.dout_re}, 0, 13) !== 4095 ||
        get_lane({16'b0, ic.dout_im}, 0, 13) !== -4096) begin
      n_bad++;
      $display("FAIL sat_clamp: re=%0d im=%0d want 4095 -4096",
               get_lane({16'b0, ic.dout_re}, 0, 13),
               get_lane({16'b0, ic.dout_im}, 0, 13));
    end
    e = vec_errs({16'b0, ic.dout_re}, {16'b0, ic.dout_im},
                 xr, xi, 16, 8, 13, 1'b0);
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL sat_model: %0d lane errors want 0", e);
    end
    n_cmp++;
    if (ic.ovf_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_set: ovf %b want 1", ic.ovf_sticky);
    end
    ic.ovf_clr = 1'b1;
    @(negedge clk);
    ic.ovf_clr = 1'b0;
    n_cmp++;
    if (ic.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clr: ovf %b want 0", ic.ovf_sticky);
    end
    // Scaled extremes fit exactly: no clip.
    send_c(xr, xi, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (get_lane({16'b0, ic.dout_re}, 0, 13) !== 4095 ||
        get_lane({16'b0, ic.dout_im}, 0, 13) !== -4096 ||
        ic.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_scaled: re=%0d im=%0d ovf=%b want 4095 -4096 0",
               get_lane({16'b0, ic.dout_re}, 0, 13),
               get_lane({16'b0, ic.dout_im}, 0, 13), ic.ovf_sticky);
    end
    send_c(xr, xi, 1'b0);
    ic.ovf_clr = 1'b1;
    @(negedge clk);
    ic.ovf_clr = 1'b0;
    n_cmp++;
    if (ic.ovf_sticky !== 1'b1 || ic.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_setclr: ovf=%b v=%b want 1 1",
               ic.ovf_sticky, ic.out_valid);
    end
  endtask

  task automatic test_stream();
    int sr [20][16];
    int si [20][16];
    bit ssc [20];
    int sent = 0, got = 0, infl = 0, cyc = 0, e;
    bit stall_prev = 1'b0, exp_rdy, acc, xfer;
    logic [223:0] pre_re, pre_im;
    logic pre_last;
    pre_re = '0; pre_im = '0; pre_last = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 16; i++) begin
        sr[k][i] = rnd13();
        si[k][i] = rnd13();
      end
      ssc[k] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      sr[3][i] = (i < 8) ? 4095 : -4096;
      si[3][i] = -4096;
    end
    ssc[3] = 1'b0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      ia.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        ia.din_re   = pack13(sr[sent]);
        ia.din_im   = pack13(si[sent]);
        ia.scale_en = ssc[sent];
        ia.in_last  = (sent == 19);
        ia.in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        ia.in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(infl == 2 && !ia.out_ready);
      n_cmp++;
      if (ia.in_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL st_ready c%0d: got %b want %b",
                 cyc, ia.in_ready, exp_rdy);
      end
      if (infl == 0) begin
        n_cmp++;
        if (ia.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL st_empty c%0d: out_valid %b want 0",
                   cyc, ia.out_valid);
        end
      end
      if (stall_prev) begin
        n_cmp++;
        if (ia.out_valid !== 1'b1 || ia.dout_re !== pre_re ||
            ia.dout_im !== pre_im || ia.out_last !== pre_last) begin
          n_bad++;
          $display("FAIL st_hold c%0d: v=%b last=%b not held",
                   cyc, ia.out_valid, ia.out_last);
        end
      end
      xfer = ia.out_valid && ia.out_ready;
      if (xfer && got < 20) begin
        e = vec_errs(ia.dout_re, ia.dout_im, sr[got], si[got],
                     16, 8, 14, ssc[got]);
        n_cmp++;
        if (e !== 0) begin
          n_bad++;
          $display("FAIL st_data v%0d: %0d lane errors want 0", got, e);
        end
        n_cmp++;
        if (ia.out_last !== (got == 19)) begin
          n_bad++;
          $display("FAIL st_last v%0d: got %b want %b",
                   got, ia.out_last, (got == 19));
        end
        got++;
      end
      acc = ia.in_valid && ia.in_ready;
      if (acc) sent++;
      infl = infl + int'(acc) - int'(xfer);
      stall_prev = ia.out_valid && !ia.out_ready;
      pre_re = ia.dout_re;
      pre_im = ia.dout_im;
      pre_last = ia.out_last;
      cyc++;
    end
    n_cmp++;
    if (got !== 20) begin
      n_bad++;
      $display("FAIL st_count: got %0d vectors want 20", got);
    end
    ia.in_valid  = 1'b0;
    ia.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b0 || ia.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL st_tail: v=%b ovf=%b want 0 0",
               ia.out_valid, ia.ovf_sticky);
    end
  endtask

  task automatic test_reset_midstream();
    vec_t xr, xi;
    int e;
    for (int i = 0; i < 16; i++) begin
      xr[i] = rnd13(); xi[i] = rnd13();
    end
    ia.out_ready = 1'b1;
    @(negedge clk);
    ia.din_re = pack13(xr); ia.din_im = pack13(xi);
    ia.scale_en = 1'b0; ia.in_last = 1'b1; ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_last = 1'b0;
    @(negedge clk);
    ia.in_valid = 1'b0;
    n_cmp++;
    if (ia.out_valid !== 1'b1 || ia.out_last !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_pre: v=%b last=%b want 1 1",
               ia.out_valid, ia.out_last);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ia.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_ready: got %b want 0", ia.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ia.out_valid !== 1'b0 || ia.out_last !== 1'b0 ||
        ia.dout_re !== '0 || ia.dout_im !== '0 ||
        ic.ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_clear: v=%b last=%b ovf=%b want 0 0 0",
               ia.out_valid, ia.out_last, ic.ovf_sticky);
    end
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_flush: out_valid %b want 0", ia.out_valid);
    end
    for (int i = 0; i < 16; i++) begin
      xr[i] = rnd13(); xi[i] = rnd13();
    end
    send_a(xr, xi, 1'b1, 1'b0);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_early: out_valid %b want 0", ia.out_valid);
    end
    @(negedge clk);
    e = vec_errs(ia.dout_re, ia.dout_im, xr, xi, 16, 8, 14, 1'b1);
    n_cmp++;
    if (ia.out_valid !== 1'b1 || e !== 0) begin
      n_bad++;
      $display("FAIL rm_after: v=%b errs=%0d want 1 0",
               ia.out_valid, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_last = 1'b0; ia.scale_en = 1'b0;
    ia.din_re = '0; ia.din_im = '0;
    ia.out_ready = 1'b1; ia.ovf_clr = 1'b0;
    ib.in_valid = 1'b0; ib.in_last = 1'b0; ib.scale_en = 1'b0;
    ib.din_re = '0; ib.din_im = '0;
    ib.out_ready = 1'b1; ib.ovf_clr = 1'b0;
    ic.in_valid = 1'b0; ic.in_last = 1'b0; ic.scale_en = 1'b0;
    ic.din_re = '0; ic.din_im = '0;
    ic.out_ready = 1'b1; ic.ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_stride1();
    test_scale();
    test_saturation();
    test_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
